clk_en_gen: RTL and testbench

Parametrised clock-enable generator with lock-qualified reset sequencing, the successor to the fixed single-output PLL wrapper. It takes the PLL output clock and the PLL `locked` flag and keeps the downstream reset asserted until lock has been stable for a programmable hold time. It then produces NCH independent, runtime-programmable single-cycle clock-enable strobes. Loss of lock re-asserts reset. Sits between the PLL wrapper and the processor/peripheral logic, so that slow domains run as enables on one clock instead of extra PLL outputs.

---
 rtl/clk_en_pkg.sv | 20 ++
 rtl/clk_en_chan.sv | 76 +++++++
 rtl/clk_en_gen.sv | 116 +++++++++++
 tb/tb_clk_en_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_pkg.sv
// clk_en_pkg: shared FSM state type, synchroniser depth
// and width helper for the clock-enable generator.
package clk_en_pkg;

    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

endpackage

// File: rtl/clk_en_chan.sv
// clk_en_chan: one enable channel with active/pending divisor,
// wrap counter and registered single-cycle strobe.
module clk_en_chan #(
    parameter int               DIV_W   = 8,
    parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_q,
    input  logic             run_d,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    output logic             pend,
    output logic             ce
);

    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pdiv_q, pdiv_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             ce_q, ce_d;
    logic             restart;

    // divisor bookkeeping: pending apply at wrap or on leaving RUN
    always_comb begin
        act_d   = act_q;
        pdiv_d  = pdiv_q;
        pend_d  = pend_q;
        restart = 1'b0;
        if (pend_q && (!run_q || !run_d || act_q == '0 || ce_q)) begin
            act_d   = pdiv_q;
            pend_d  = 1'b0;
            restart = 1'b1;
        end else if (wr_en) begin
            if (run_q) begin
                pdiv_d = wr_div;
                pend_d = 1'b1;
            end else begin
                act_d = wr_div;
            end
        end
    end

    // counter runs 0..d-1, strobe on the last count
    always_comb begin
        cnt_d = '0;
        ce_d  = 1'b0;
        if (run_d && act_d != '0) begin
            if (run_q && !restart && !ce_q) begin
                cnt_d = cnt_q + DIV_W'(1);
            end
            ce_d = (cnt_d == act_d - DIV_W'(1));
        end
    end

    // channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q  <= RST_DIV;
            pdiv_q <= '0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
            ce_q   <= 1'b0;
        end else begin
            act_q  <= act_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            ce_q   <= ce_d;
        end
    end

    assign pend = pend_q;
    assign ce   = ce_q;

endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: lock-qualified reset sequencer driving NCH
// runtime-programmable clock-enable channels.
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int                   NCH         = 4,
    parameter int                   DIV_W       = 8,
    parameter logic [NCH*DIV_W-1:0] DEF_DIV     = {NCH{8'd1}},
    parameter int                   HOLD_CYCLES = 1024,
    localparam int                  CH_W        = (NCH > 1) ? clog2(NCH) : 1
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             cfg_valid,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic [NCH-1:0]   ce,
    output logic             rst_out_n,
    output logic             running
);

    localparam int              HC_W      = clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic                  lock_s;
    state_e                state_q, state_d;
    logic [HC_W-1:0]       hold_q, hold_d, hold_inc;
    logic                  run_q, run_d;
    logic [NCH-1:0]        pend;
    logic [NCH-1:0]        wr_en;

    // shift the asynchronous lock flag through the synchroniser
    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], pll_locked};
    end

    assign lock_s = sync_q[SYNC_DEPTH-1];

    // sequencing: wait for lock, hold it stable, then run
    always_comb begin
        state_d  = state_q;
        hold_d   = '0;
        hold_inc = hold_q + HC_W'(1);
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = (HOLD_LAST == '0) ? RUN : HOLD;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (hold_inc >= HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_inc;
                end
            end
            RUN: begin
                if (!lock_s) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
        run_d = (state_d == RUN);
    end

    // synchroniser, FSM state and registered run flag
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= WAIT_LOCK;
            hold_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            run_q   <= run_d;
        end
    end

    // write steering; out-of-range channels accept and drop
    always_comb begin
        cfg_ready = 1'b1;
        wr_en     = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pend[i];
                wr_en[i]  = cfg_valid && !pend[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_en_chan #(
            .DIV_W   (DIV_W),
            .RST_DIV (DEF_DIV[g*DIV_W +: DIV_W])
        ) u_chan (
            .clk    (refclk),
            .rst_n  (rst_n),
            .run_q  (run_q),
            .run_d  (run_d),
            .wr_en  (wr_en[g]),
            .wr_div (cfg_div),
            .pend   (pend[g]),
            .ce     (ce[g])
        );
    end

    assign rst_out_n = run_q;
    assign running   = run_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed bench with a cycle-level reference
// model of lock sequencing and enable periods.
module tb_clk_en_gen;

    localparam int NCH = 4;
    localparam int H   = 16;

    logic           refclk = 1'b0;
    logic           rst_n;
    logic           pll_locked;
    logic           cfg_valid;
    logic [1:0]     cfg_ch;
    logic [7:0]     cfg_div;
    logic           cfg_ready;
    logic [NCH-1:0] ce;
    logic           rst_out_n;
    logic           running;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    clk_en_gen #(
        .NCH         (NCH),
        .DIV_W       (8),
        .DEF_DIV     ({NCH{8'd1}}),
        .HOLD_CYCLES (H)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .cfg_valid  (cfg_valid),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .ce         (ce),
        .rst_out_n  (rst_out_n),
        .running    (running)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, got, exp, $time);
    endtask

    // reference model: lock must be seen H times in a row
    // after the 2-stage delay; channel strobes from phase mod d
    logic           m_s0, m_s1, m_run;
    int             m_streak;
    int             m_act[NCH];
    int             m_pdiv[NCH];
    bit             m_pend[NCH];
    int             m_t[NCH];
    logic [NCH-1:0] m_ce;

    function automatic bit m_ready();
        return !m_pend[cfg_ch];
    endfunction

    task automatic model_reset();
        m_s0 = 0; m_s1 = 0; m_run = 0; m_streak = 0; m_ce = '0;
        for (int i = 0; i < NCH; i++) begin
            m_act[i] = 1; m_pdiv[i] = 0; m_pend[i] = 0; m_t[i] = 0;
        end
    endtask

    task automatic model_step();
        logic           run_prev;
        logic [NCH-1:0] ce_prev;
        bit             rdy;
        bit             rs;
        run_prev = m_run;
        ce_prev  = m_ce;
        rdy      = m_ready();
        if (m_s1) begin
            if (m_streak < 1000) m_streak++;
        end else begin
            m_streak = 0;
        end
        m_run = (m_streak >= H);
        m_s1 = m_s0;
        m_s0 = pll_locked;
        for (int i = 0; i < NCH; i++) begin
            rs = 0;
            if (m_pend[i] && (!run_prev || !m_run ||
                              m_act[i] == 0 || ce_prev[i])) begin
                m_act[i] = m_pdiv[i]; m_pend[i] = 0; rs = 1;
            end else if (cfg_valid && rdy && int'(cfg_ch) == i) begin
                if (run_prev) begin
                    m_pdiv[i] = int'(cfg_div); m_pend[i] = 1;
                end else begin
                    m_act[i] = int'(cfg_div);
                end
            end
            if (!m_run) begin
                m_t[i] = 0; m_ce[i] = 0;
            end else begin
                if (!run_prev || rs) m_t[i] = 0;
                else m_t[i]++;
                m_ce[i] = 0;
                if (m_act[i] != 0)
                    m_ce[i] = (m_t[i] % m_act[i] == m_act[i] - 1);
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge refclk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // every-cycle comparison against the model
    always @(negedge refclk) begin
        if (chk_en)
            chk("cycle", 32'({rst_out_n, running, ce, cfg_ready}),
                32'({m_run, m_run, m_ce, m_ready()}));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic write(input logic [1:0] ch, input logic [7:0] d);
        cfg_valid = 1; cfg_ch = ch; cfg_div = d;
        tick(1);
        cfg_valid = 0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!rst_out_n && n < 100);
    endtask

    int       n;
    bit [7:0] v;
    bit [5:0] v1, v3;
    bit [2:0] rb;
    bit       orv;

    initial begin
        rst_n = 0; pll_locked = 0;
        cfg_valid = 0; cfg_ch = 0; cfg_div = 0;
        tick(3);
        chk("reset_vals", 32'({rst_out_n, running, ce, cfg_ready}),
            32'(7'b0000001));
        rst_n = 1;
        chk_en = 1;
        tick(2);
        write(2'd1, 8'd4);
        write(2'd2, 8'd0);
        pll_locked = 1;
        wait_run(n);
        chk("lock_latency", 32'(n), 32'd18);
        chk("ce_at_release", 32'(ce), 32'(4'b1001));

        orv = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            v[k] = ce[1];
            orv |= ce[2];
        end
        chk("ch1_div4_pattern", 32'(v), 32'(8'b0100_0100));
        chk("ch2_disabled", 32'(orv), 32'd0);

        tick(1);
        cfg_valid = 1; cfg_ch = 2'd1; cfg_div = 8'd3;
        tick(1);
        chk("ready_pending", 32'(cfg_ready), 32'd0);
        cfg_div = 8'd7;
        tick(1);
        chk("old_period_end", 32'(ce[1]), 32'd1);
        chk("ready_still_low", 32'(cfg_ready), 32'd0);
        cfg_ch = 2'd3; cfg_div = 8'd2;
        #1;
        chk("ready_other_ch", 32'(cfg_ready), 32'd1);
        tick(1);
        cfg_valid = 0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            v1[k] = ce[1];
            v3[k] = ce[3];
        end
        chk("ch1_div3_pattern", 32'(v1), 32'(6'b010010));
        chk("ch3_div2_pattern", 32'(v3), 32'(6'b101010));

        pll_locked = 0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            rb[k] = rst_out_n;
        end
        chk("loss_sequence", 32'(rb), 32'(3'b011));
        chk("loss_ce", 32'(ce), 32'd0);

        pll_locked = 1;
        tick(5);
        pll_locked = 0;
        tick(1);
        pll_locked = 1;
        wait_run(n);
        chk("hold_restart", 32'(n), 32'd18);
        chk("ce_reentry", 32'(ce), 32'(4'b0001));

        tick(3);
        #2;
        rst_n = 0;
        cfg_ch = 2'd1;
        #1;
        chk("async_reset", 32'({rst_out_n, running, ce, cfg_ready}),
            32'(7'b0000001));
        @(posedge refclk);
        #1;
        rst_n = 1;
        wait_run(n);
        chk("relock_after_reset", 32'(n), 32'd18);
        chk("default_divs", 32'(ce), 32'(4'b1111));
        tick(4);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
